// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder with carry-in. Both operands are consumed
//   LSB-first through a single full-adder cell and a carry flop, one bit per
//   clock. A start/busy/done handshake frames each operation.
//
// Parameters
//   WIDTH  operand and sum width in bits (2 or more)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; only sampled while not busy (IDLE or DONE)
//   a, b   augend / addend, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   busy   high while bits are being processed
//   done   one-cycle pulse; sum/cout are valid from this cycle
//   sum    registered result, held until the next completion
//   cout   registered final carry-out, held with sum
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] ra_reg, rb_reg, rs_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] rs_next;

    // Single full-adder cell working on the current LSBs.
    always_comb begin
        s_bit    = ra_reg[0] ^ rb_reg[0] ^ carry_reg;
        c_bit    = (ra_reg[0] & rb_reg[0]) | (ra_reg[0] & carry_reg) | (rb_reg[0] & carry_reg);
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
        rs_next  = {s_bit, rs_reg[WIDTH-1:1]};
        last_bit = (cnt_reg == LAST);
        // DONE accepts a new start just like IDLE, giving back-to-back operation.
        accept   = start && (state_reg != SHIFT);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand shifters, carry flop, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_reg    <= '0;
            rb_reg    <= '0;
            rs_reg    <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else if (accept) begin
            ra_reg    <= a;
            rb_reg    <= b;
            rs_reg    <= '0;
            carry_reg <= cin;
            cnt_reg   <= '0;
        end else if (state_reg == SHIFT) begin
            ra_reg    <= {1'b0, ra_reg[WIDTH-1:1]};
            rb_reg    <= {1'b0, rb_reg[WIDTH-1:1]};
            rs_reg    <= rs_next;
            carry_reg <= c_bit;
            cnt_reg   <= cnt_reg + CW'(1);
            // Results are only published on the completing edge, so partial
            // sums never appear on the outputs.
            if (last_bit) begin
                sum_reg  <= rs_next;
                cout_reg <= c_bit;
            end
        end
    end

    always_comb begin
        busy = (state_reg == SHIFT);
        done = (state_reg == DONE);
        sum  = sum_reg;
        cout = cout_reg;
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder: a WIDTH=8 instance for directed
//   scenarios and a WIDTH=4 instance for the exhaustive sweep. Expected
//   {cout,sum} values are pushed to a queue when a start is driven and
//   popped when done is seen.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int pass_cnt;
    int total_cnt;

    logic [8:0] exp8_q[$];
    logic [4:0] exp4_q[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse on the 8-bit DUT (at a falling edge) and record
    // the expected result.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        exp8_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
        $display("drive8: a=%02h b=%02h cin=%0d", a, b, c);
    endtask

    // Wait for done on the 8-bit DUT. m is the index of the falling edge
    // (0 = first after the start edge) at which done was seen.
    task automatic wait_done8(output int m, output int busy_n, output bit got, output bit held);
        logic [7:0] prev_sum;
        logic       prev_cout;
        prev_sum = sum8; prev_cout = cout8;
        m = -1; busy_n = 0; got = 1'b0; held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) start8 = 1'b0;
            if (done8) begin
                m = i; got = 1'b1;
                break;
            end
            if (busy8) busy_n++;
            if (sum8 !== prev_sum || cout8 !== prev_cout) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy8, done8, cout8, sum8} !== 11'd0)
            $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%02h, required all 0", busy8, done8, cout8, sum8);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({busy8, done8} !== 2'b00)
            $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy8, done8);
        else pass_cnt++;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int m, bn; bit got, held;
        logic [8:0] exp;
        drive8(8'h3C, 8'h5A, 1'b0);
        wait_done8(m, bn, got, held);
        total_cnt++;
        if (!got || m != 8)
            $display("FAIL basic_latency: done at cycle %0d (got=%0d), required 8", m, got);
        else pass_cnt++;
        total_cnt++;
        if (bn != 8)
            $display("FAIL basic_busy_cycles: %0d, required 8", bn);
        else pass_cnt++;
        total_cnt++;
        if (busy8 !== 1'b0)
            $display("FAIL basic_busy_with_done: busy=%b, required 0", busy8);
        else pass_cnt++;
        total_cnt++;
        if (!held)
            $display("FAIL basic_no_partial: sum/cout changed before done, required hold");
        else pass_cnt++;
        exp = exp8_q.pop_front();
        total_cnt++;
        if ({cout8, sum8} !== exp)
            $display("FAIL basic_result: cout=%b sum=%02h, required cout=%b sum=%02h", cout8, sum8, exp[8], exp[7:0]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done8 !== 1'b0 || {cout8, sum8} !== exp)
            $display("FAIL basic_done_pulse_hold: done=%b sum=%02h, required done=0 sum=%02h", done8, sum8, exp[7:0]);
        else pass_cnt++;
        $display("test_basic: 3C+5A -> cout=%b sum=%02h", cout8, sum8);
    endtask

    task automatic test_carry();
        logic [7:0] ta[3];
        logic [7:0] tb[3];
        logic       tc[3];
        int m, bn; bit got, held;
        logic [8:0] exp;
        ta = '{8'hFF, 8'hFF, 8'h00};
        tb = '{8'h01, 8'hFF, 8'h00};
        tc = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            drive8(ta[k], tb[k], tc[k]);
            wait_done8(m, bn, got, held);
            exp = exp8_q.pop_front();
            total_cnt++;
            if (!got || {cout8, sum8} !== exp)
                $display("FAIL carry_case%0d: got=%0d cout=%b sum=%02h, required cout=%b sum=%02h",
                         k, got, cout8, sum8, exp[8], exp[7:0]);
            else pass_cnt++;
            $display("test_carry: %02h+%02h+%0d -> cout=%b sum=%02h", ta[k], tb[k], tc[k], cout8, sum8);
        end
    endtask

    task automatic test_ignore_busy();
        int done_n;
        logic [8:0] exp;
        drive8(8'd10, 8'd25, 1'b0);
        done_n = 0;
        exp = 9'h0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (i == 3) begin
                a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
            end
            if (done8) begin
                done_n++;
                if (exp8_q.size() > 0) exp = exp8_q.pop_front();
                total_cnt++;
                if ({cout8, sum8} !== exp)
                    $display("FAIL ignore_result: cout=%b sum=%02h, required cout=%b sum=%02h", cout8, sum8, exp[8], exp[7:0]);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done_n != 1)
            $display("FAIL ignore_done_count: %0d, required 1", done_n);
        else pass_cnt++;
        $display("test_ignore_busy: done pulses=%0d sum=%02h", done_n, sum8);
    endtask

    task automatic test_abort();
        int m, bn, done_n; bit got, held;
        logic [8:0] exp;
        drive8(8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst_n = 1'b0;
        exp8_q.delete();
        #1;
        total_cnt++;
        if ({busy8, done8, cout8, sum8} !== 11'd0)
            $display("FAIL abort_outputs: busy=%b done=%b cout=%b sum=%02h, required all 0", busy8, done8, cout8, sum8);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 || busy8) done_n++;
        end
        total_cnt++;
        if (done_n != 0)
            $display("FAIL abort_no_done: %0d active cycles, required 0", done_n);
        else pass_cnt++;
        drive8(8'h80, 8'h80, 1'b0);
        wait_done8(m, bn, got, held);
        exp = exp8_q.pop_front();
        total_cnt++;
        if (!got || m != 8 || {cout8, sum8} !== exp)
            $display("FAIL abort_restart: got=%0d cycle=%0d cout=%b sum=%02h, required cycle 8 cout=%b sum=%02h",
                     got, m, cout8, sum8, exp[8], exp[7:0]);
        else pass_cnt++;
        $display("test_abort: restart 80+80 -> cout=%b sum=%02h", cout8, sum8);
    endtask

    task automatic test_back_to_back();
        int m, bn; bit got, held;
        logic [8:0] exp;
        drive8(8'd1, 8'd2, 1'b0);
        wait_done8(m, bn, got, held);
        exp = exp8_q.pop_front();
        total_cnt++;
        if (!got || {cout8, sum8} !== exp)
            $display("FAIL b2b_first: cout=%b sum=%02h, required cout=%b sum=%02h", cout8, sum8, exp[8], exp[7:0]);
        else pass_cnt++;
        // Start held during the done cycle of the first operation.
        a8 = 8'd7; b8 = 8'd8; cin8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(9'd15);
        wait_done8(m, bn, got, held);
        exp = exp8_q.pop_front();
        total_cnt++;
        if (!got || {cout8, sum8} !== exp)
            $display("FAIL b2b_second: cout=%b sum=%02h, required cout=%b sum=%02h", cout8, sum8, exp[8], exp[7:0]);
        else pass_cnt++;
        // Falling edges from first done to second done = m + 1.
        total_cnt++;
        if (m + 1 != 9)
            $display("FAIL b2b_spacing: %0d cycles, required 9", m + 1);
        else pass_cnt++;
        $display("test_back_to_back: second result sum=%02h spacing=%0d", sum8, m + 1);
    endtask

    task automatic test_exhaustive4();
        logic [4:0] exp;
        bit got;
        int errs;
        errs = 0;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    @(negedge clk);
                    a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
                    exp4_q.push_back(5'(ai + bi + ci));
                    got = 1'b0;
                    for (int i = 0; i < 20; i++) begin
                        @(negedge clk);
                        start4 = 1'b0;
                        if (done4) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    exp = exp4_q.pop_front();
                    total_cnt++;
                    if (!got || {cout4, sum4} !== exp) begin
                        errs++;
                        $display("FAIL exh4 a=%0h b=%0h cin=%0d: got=%0d cout=%b sum=%0h, required cout=%b sum=%0h",
                                 ai, bi, ci, got, cout4, sum4, exp[4], exp[3:0]);
                    end else pass_cnt++;
                end
            end
        end
        $display("test_exhaustive4: 512 cases, %0d errors", errs);
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_busy();
        test_abort();
        test_back_to_back();
        test_exhaustive4();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
